// File: rtl/mem_sram_controller_pkg.sv
// mem_sram_controller_pkg: shared SRAM geometry, default base address and controller state encoding
package mem_sram_controller_pkg;
    localparam int LEN_SRAM_ADDR = 18;
    localparam int LEN_SRAM_DATA = 16;
    localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: 4-bit loadable down-counter timing one halfword phase
module sram_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_value,
    output logic       o_zero
);
    logic [3:0] r_count;
    // reload at the start of a phase, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst)
        if (rst) r_count <= '0;
        else if (i_load) r_count <= i_value;
        else if (r_count != 4'd0) r_count <= r_count - 4'd1;
    assign o_zero = (r_count == 4'd0);
endmodule

// File: rtl/mem_sram_controller.sv
// mem_sram_controller: splits 32-bit loads/stores into two 16-bit SRAM phases, stalling the pipeline meanwhile
module mem_sram_controller
    import mem_sram_controller_pkg::*;
#(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    output logic [LEN_SRAM_ADDR-1:0] sram_addr,
    inout  wire  [LEN_SRAM_DATA-1:0] sram_dq,
    output logic                     sram_we_n,
    output logic                     sram_ce_n,
    output logic                     sram_oe_n,
    output logic                     sram_ub_n,
    output logic                     sram_lb_n
);
    state_t                   r_state;
    state_t                   w_next;
    logic                     r_is_write;
    logic [LEN_SRAM_ADDR-2:0] r_word_idx;
    logic [31:0]              r_wdata;
    logic [31:0]              r_read_data;
    logic [31:0]              w_offset;
    logic [LEN_SRAM_DATA-1:0] w_dq_out;
    logic                     w_req;
    logic                     w_zero;
    logic                     w_load;
    logic                     w_wr_phase;
    logic                     w_we_n;
    logic                     w_unused;

    assign w_req      = mem_read | mem_write;
    assign w_offset   = address - MEM_BASE;
    assign w_unused   = ^{w_offset[31:LEN_SRAM_ADDR+1], w_offset[1:0]};
    assign w_load     = ((r_state == S_IDLE) & w_req) | ((r_state == S_LO) & w_zero);
    assign w_wr_phase = r_is_write & ((r_state == S_LO) | (r_state == S_HI));

    sram_wait_counter u_wait (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (4'(WAIT_CYCLES - 1)),
        .o_zero  (w_zero)
    );

    // state register; reset aborts any access at once
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;

    // next state and per-phase SRAM strobes; we_n rises in the last cycle to give data hold
    always_comb begin
        w_next   = r_state;
        w_dq_out = (r_state == S_HI) ? r_wdata[31:16] : r_wdata[15:0];
        w_we_n   = ~(w_wr_phase & ~w_zero);
        case (r_state)
            S_IDLE:  w_next = w_req ? S_LO : S_IDLE;
            S_LO:    w_next = w_zero ? S_HI : S_LO;
            S_HI:    w_next = w_zero ? S_DONE : S_HI;
            default: w_next = S_IDLE;
        endcase
    end

    // capture request type, word index and store data when the access is accepted
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_is_write <= 1'b0;
            r_word_idx <= '0;
            r_wdata    <= '0;
        end else if ((r_state == S_IDLE) && w_req) begin
            r_is_write <= mem_write;
            r_word_idx <= w_offset[LEN_SRAM_ADDR:2];
            r_wdata    <= write_data;
        end

    // sample the bus on the edge closing each read phase
    always_ff @(posedge clk or posedge rst)
        if (rst) r_read_data <= '0;
        else if (w_zero && !r_is_write) begin
            if (r_state == S_LO) r_read_data[15:0] <= sram_dq;
            else if (r_state == S_HI) r_read_data[31:16] <= sram_dq;
        end

    assign read_data = r_read_data;
    assign ready     = ~w_req | (r_state == S_DONE);
    assign sram_addr = {r_word_idx, r_state == S_HI};
    assign sram_dq   = w_wr_phase ? w_dq_out : 'z;
    assign sram_we_n = w_we_n;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
endmodule

// File: doc/mem_sram_controller.md
# mem_sram_controller

Memory-stage consumer of the execute stage's ALU result. It turns a 32-bit word load or store request into two 16-bit accesses on the external SRAM (IS61LV25616-class) and holds `ready` low to freeze the pipeline until the access completes. It sits between the EX/MEM pipeline register and the MEM/WB register, using `alu_result` as the byte address and `val_rm` as the store data.

## Interface
Parameters:
- `WAIT_CYCLES`, default 3: cycles per halfword phase. Legal range is 2..15.
- `MEM_BASE`, default 1024: byte address that maps to SRAM word 0.

Ports (the single clock is `clk`; `rst` is asynchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  load request, held stable while `ready`=0.
- `mem_write`  in  1  store request, held stable while `ready`=0.
- `address`  in  32  byte address (ALU result). Bits [1:0] are ignored.
- `write_data`  in  32  store data (`val_rm`).
- `read_data`  out  32  load result, registered.
- `ready`  out  1  when 0, the pipeline freezes.
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq`  inout  16  SRAM data bus.
- `sram_we_n`  out  1  active-low write enable.
- `sram_ce_n`, `sram_oe_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  tied to 0.

## Operation
**States:** IDLE, LO, HI, DONE.

**IDLE**
- If `mem_write`, go to LO with a write in progress. Otherwise, if `mem_read`, go to LO with a read in progress.
- If both are asserted, write wins.
- The request type and address are latched on this transition.

**LO and HI**
- Each phase lasts exactly `WAIT_CYCLES` cycles, timed by the wait counter.
- LO then goes to HI; HI then goes to DONE.

**DONE**
- Lasts one cycle, then returns to IDLE unconditionally.

**Address mapping**
- `word_idx = (address - MEM_BASE) >> 2`, computed modulo 2^32.
- `sram_addr = {word_idx[16:0], phase}`, where phase is 0 in LO and 1 in HI.
- Addresses below `MEM_BASE` wrap; no error is flagged.

**Data ordering (little-endian)**
- The LO phase carries bits [15:0]; the HI phase carries bits [31:16].

**Writes**
- `sram_dq` is driven with the selected halfword for the whole phase.
- `sram_we_n` is 0 for the first `WAIT_CYCLES-1` cycles of the phase and 1 in the last cycle. This gives data hold past the write strobe.

**Reads**
- `sram_dq` is tri-stated and `sram_we_n` is 1.
- `sram_dq` is sampled on the clock edge that ends each phase, into `read_data[15:0]` for LO and `read_data[31:16]` for HI.
- `read_data` keeps its value until the next read overwrites it. A write never changes it.

**ready**
- `ready = ~(mem_read | mem_write) | (state == DONE)`. It is combinational from the request inputs.

**Outside a write phase**
- `sram_dq` is high-Z and `sram_we_n` is 1.

## Timing
- **Reset values:** state IDLE, `read_data`=0, `sram_we_n`=1, `sram_dq` Z, `sram_addr`=0, wait counter 0. With no request present, `ready`=1.
- **Reset mid-access:** the controller aborts immediately to IDLE and `we_n` deasserts asynchronously. A partial write leaves the LO halfword written.
- **Latency:** a request first seen in IDLE at cycle 0 occupies LO for cycles 1..W and HI for cycles W+1..2W, where W = `WAIT_CYCLES`. DONE is cycle 2W+1, and `ready`=1 there. The total is 2W+2 cycles including the IDLE cycle; with W=3 that is `ready` low for 7 cycles and high in the 8th.
- **Validity:** `read_data` is valid from DONE onward.
- **Back-to-back requests:** the request following DONE is sampled in the next IDLE cycle. There is no extra bubble beyond that IDLE cycle.
- **Input changes while busy:** changes to request inputs while not in IDLE are ignored, because the latched type and address are used. Dropping the request mid-access does not abort it.

## Structure
- **Shared package:** `LEN_SRAM_ADDR`=18, `LEN_SRAM_DATA`=16, `MEM_BASE` default, and the state encoding (2-bit enum: IDLE=0, LO=1, HI=2, DONE=3).
- **Sub-module `sram_wait_counter`:** 4-bit down-counter with `load` and `zero` outputs, reused for both phases.

## Test plan
- **Idle outputs:** idle, no request -> `ready`=1, `sram_we_n`=1, `sram_dq`=Z, and `read_data` holds 0 after reset.
- **Word store:** store 0x12345678 to address 1024 with W=3 -> SRAM model holds [0]=0x5678 and [1]=0x1234. `we_n` low exactly 2 cycles per phase, `ready` low 7 cycles, and `ready`=1 in cycle 8.
- **Word load:** load from 1028 after the model is preloaded with [2]=0xBEEF, [3]=0xDEAD -> `sram_addr` sequence 2 then 3, and `read_data`=0xDEADBEEF at DONE.
- **Back-to-back:** store to 1032 followed by a load from 1032 -> the load returns the stored word, and the second access starts exactly one IDLE cycle after DONE.
- **Reset mid-write:** assert `rst` during HI -> state IDLE, `we_n`=1 and `dq`=Z at once, the model shows only the LO halfword written, and the next request completes normally.
- **Simultaneous read and write:** `mem_read`=`mem_write`=1 at address 1024 -> treated as a write, and `read_data` is unchanged.
